alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, meaning operand/result width (legal: 8, 16, 32, 64).
REQ-002 The block SHALL take parameter CTRL_WIDTH, default 4, meaning opcode width (fixed at 4 for this revision).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- alu_ctrl  in  CTRL_WIDTH  opcode
- op1  in  DATA_WIDTH  operand 1
- op2  in  DATA_WIDTH  operand 2 (register or immediate)
- flush  in  1  synchronous abort of any in-flight operation
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- alu_out  out  DATA_WIDTH  result
- eq  out  1  op1 == op2
- lt  out  1  op1 < op2, signed
- ltu  out  1  op1 < op2, unsigned

Function
REQ-005 The opcode encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT, 0110 SRL, 0111 SRA, 1000 SLTU, 1001 XOR, 1010 MUL (low half), 1011 MULHU (high half, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-006 A request SHALL be accepted on a rising clk edge where in_valid && in_ready; op1, op2 and alu_ctrl SHALL be captured then and not resampled.
REQ-007 The FSM SHALL have states IDLE, BUSY and DONE, with in_ready = 1 only in IDLE.
REQ-008 Transitions SHALL be:
- IDLE -> DONE on accepting opcodes 0000-1001
- IDLE -> BUSY on accepting opcodes 1010-1111
- BUSY -> DONE when the iteration counter reaches DATA_WIDTH
- DONE -> IDLE on out_ready
REQ-009 Single-cycle opcodes SHALL present out_valid on the cycle after acceptance (latency 1).
REQ-010 Mul/div opcodes SHALL take one radix-2 iteration per cycle, presenting out_valid exactly DATA_WIDTH+1 cycles after acceptance, independent of operand values.
REQ-011 out_valid SHALL equal 1 only in DONE; alu_out, eq, lt and ltu SHALL be held stable while out_valid && !out_ready.
REQ-012 Shift amount SHALL be op2[$clog2(DATA_WIDTH)-1:0]; upper op2 bits are ignored; SRA SHALL replicate op1 MSB.
REQ-013 SLT/SLTU SHALL output zero-extended 1 or 0; ADD/SUB/MUL SHALL wrap modulo 2^DATA_WIDTH.
REQ-014 eq, lt and ltu SHALL be computed from the captured operands for every opcode and registered alongside alu_out.
REQ-015 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return op1. This still takes full latency.
REQ-016 Signed overflow (op1 = most-negative, op2 = -1): DIV SHALL return op1; REM SHALL return 0.
REQ-017 DIV/REM SHALL be signed truncating toward zero, with the remainder taking the sign of op1.
REQ-018 flush SHALL force IDLE on the next edge from any state, deassert out_valid and discard the result; flush has priority over acceptance in the same cycle.
REQ-019 An in_valid arriving while in BUSY or DONE SHALL be ignored (in_ready = 0); no request is lost if the requester holds in_valid.

Reset
REQ-020 On rst assertion, the block SHALL immediately (asynchronously) enter IDLE with:
- out_valid = 0, alu_out = 0, eq = lt = ltu = 0
- iteration counter = 0, in_ready = 1
REQ-021 rst during BUSY or DONE SHALL abandon the operation; the first post-reset result SHALL come only from a new accepted request.

Verification
REQ-022 ADD op1=0xFFFFFFFF, op2=1, out_ready=1 -> cycle+1: out_valid=1, alu_out=0, eq=0, lt=1, ltu=0.
REQ-023 SRA op1=0x80000000, op2=0x24 -> alu_out=0xF8000000 (shift 4); SRL same operands -> 0x08000000.
REQ-024 DIV op1=-7, op2=2 -> out_valid at cycle+33, alu_out=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-025 DIVU op1=5, op2=0 -> 0xFFFFFFFF; REM op1=0x80000000, op2=0xFFFFFFFF -> 0; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-026 MUL accepted, then flush at cycle+10 -> out_valid stays 0 and in_ready=1 at cycle+11; likewise rst pulse at cycle+10 -> outputs zero immediately.
REQ-027 Result held with out_ready=0 for 5 cycles and in_valid held high -> alu_out stable, in_ready=0 throughout; the next request is accepted the cycle after out_ready=1.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - Sequential ALU with single-cycle ops and radix-2 multiply/divide.
// Mul/div run one shift-add or restoring-subtract step per cycle on operand magnitudes.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  eq,
    output logic                  lt,
    output logic                  ltu
);

    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] W_ONE    = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_alu_out;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_ltu;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mq;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [2:0]            r_mode;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_dvz;

    logic [SH_W-1:0]       w_sh;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_ltu;
    logic                  w_multi;
    logic                  w_sdiv;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH-1:0] w_fast;
    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH:0]   w_rem_sub;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_acc_nx;
    logic [DATA_WIDTH-1:0] w_mq_nx;
    logic [DATA_WIDTH-1:0] w_fin;

    assign w_sh    = op2[SH_W-1:0];
    assign w_eq    = (op1 == op2);
    assign w_lt    = ($signed(op1) < $signed(op2));
    assign w_ltu   = (op1 < op2);
    assign w_multi = alu_ctrl[3] & (alu_ctrl[2] | alu_ctrl[1]);
    assign w_sdiv  = alu_ctrl[3] & alu_ctrl[2] & ~alu_ctrl[0];

    // Magnitudes only differ from the raw operands for signed DIV/REM.
    assign w_a_mag = (w_sdiv && op1[DATA_WIDTH-1]) ? (~op1 + W_ONE) : op1;
    assign w_b_mag = (w_sdiv && op2[DATA_WIDTH-1]) ? (~op2 + W_ONE) : op2;

    always_comb begin
        w_fast = '0;
        case (alu_ctrl)
            4'b0000: w_fast = op1 + op2;
            4'b0001: w_fast = op1 - op2;
            4'b0010: w_fast = op1 & op2;
            4'b0011: w_fast = op1 | op2;
            4'b0100: w_fast = op1 << w_sh;
            4'b0101: w_fast = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            4'b0110: w_fast = op1 >> w_sh;
            4'b0111: w_fast = $signed(op1) >>> w_sh;
            4'b1000: w_fast = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            4'b1001: w_fast = op1 ^ op2;
            default: w_fast = '0;
        endcase
    end

    // {r_acc, r_mq} is the running product (mul) or partial remainder / quotient (div).
    assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_dvs} : '0);
    assign w_rem_sh  = {r_acc, r_mq[DATA_WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = ~w_rem_sub[DATA_WIDTH];

    always_comb begin
        w_acc_nx = w_mul_sum[DATA_WIDTH:1];
        w_mq_nx  = {w_mul_sum[0], r_mq[DATA_WIDTH-1:1]};
        if (r_mode[2]) begin
            w_acc_nx = w_ge ? w_rem_sub[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
            w_mq_nx  = {r_mq[DATA_WIDTH-2:0], w_ge};
        end
    end

    always_comb begin
        w_fin = w_mq_nx;
        case (r_mode[2:1])
            2'b01: w_fin = r_mode[0] ? w_acc_nx : w_mq_nx;
            2'b10: begin
                if (r_dvz)        w_fin = '1;
                else if (r_neg_q) w_fin = ~w_mq_nx + W_ONE;
                else              w_fin = w_mq_nx;
            end
            2'b11: begin
                if (r_dvz)        w_fin = r_op1;
                else if (r_neg_r) w_fin = ~w_acc_nx + W_ONE;
                else              w_fin = w_acc_nx;
            end
            default: w_fin = w_mq_nx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mq        <= '0;
            r_dvs       <= '0;
            r_op1       <= '0;
            r_mode      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvz       <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_eq       <= w_eq;
                        r_lt       <= w_lt;
                        r_ltu      <= w_ltu;
                        r_op1      <= op1;
                        r_mode     <= alu_ctrl[2:0];
                        r_acc      <= '0;
                        r_mq       <= w_a_mag;
                        r_dvs      <= w_b_mag;
                        r_cnt      <= '0;
                        r_neg_q    <= w_sdiv & (op1[DATA_WIDTH-1] ^ op2[DATA_WIDTH-1]);
                        r_neg_r    <= w_sdiv & op1[DATA_WIDTH-1];
                        r_dvz      <= (op2 == '0);
                        r_in_ready <= 1'b0;
                        if (w_multi) begin
                            r_state <= S_BUSY;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_alu_out   <= w_fast;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nx;
                    r_mq  <= w_mq_nx;
                    r_cnt <= r_cnt + CNT_ONE;
                    // The last step's result is folded straight into alu_out.
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_alu_out   <= w_fin;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign ltu       = r_ltu;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - Self-checking bench for alu_muldiv_seq with a behavioural reference model.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        eq;
    logic        lt;
    logic        ltu;

    alu_muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        p   = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a << b[4:0];
            4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: return a >> b[4:0];
            4'h7: return $signed(a) >>> b[4:0];
            4'h8: return (a < b) ? 32'd1 : 32'd0;
            4'h9: return a ^ b;
            4'hA: return p[31:0];
            4'hB: return p[63:32];
            4'hC: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hE: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        e;
        logic        l;
        logic        lu;
        int          due;
    } exp_t;

    exp_t q[$];
    bit   m_idle;
    bit   m_ev;
    exp_t m_new;

    // Reference: one pending result at a time, visible from its due cycle until consumed.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            m_idle = (q.size() == 0);
            m_ev   = !m_idle && (cyc >= q[0].due);
            chk("in_ready", 64'(in_ready), 64'(m_idle));
            chk("out_valid", 64'(out_valid), 64'(m_ev));
            if (m_ev) begin
                chk("alu_out", 64'(alu_out), 64'(q[0].res));
                chk("eq", 64'(eq), 64'(q[0].e));
                chk("lt", 64'(lt), 64'(q[0].l));
                chk("ltu", 64'(ltu), 64'(q[0].lu));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_ev && out_ready) void'(q.pop_front());
                if (m_idle && in_valid) begin
                    m_new.res = model(alu_ctrl, op1, op2);
                    m_new.e   = (op1 == op2);
                    m_new.l   = ($signed(op1) < $signed(op2));
                    m_new.lu  = (op1 < op2);
                    m_new.due = cyc + ((alu_ctrl >= 4'hA) ? 33 : 1);
                    q.push_back(m_new);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        alu_ctrl = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) chk("accept_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    task automatic wait_result(input string name, input int lat, input bit has_exp, input logic [31:0] exp);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(lat));
        if (has_exp) chk(name, 64'(alu_out), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r;
        vq.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'h0;
        op1       = '0;
        op2       = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_alu_out", 64'(alu_out), 64'(0));
        chk("rst_flags", 64'({eq, lt, ltu}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD wrap with explicit flags.
        send(4'h0, 32'hFFFF_FFFF, 32'h1);
        chk("add_flags", 64'({eq, lt, ltu}), 64'(3'b010));
        wait_result("add_wrap", 1, 1'b1, 32'h0);

        add_vec(4'h7, 32'h8000_0000, 32'h24, 32'hF800_0000);
        add_vec(4'h6, 32'h8000_0000, 32'h24, 32'h0800_0000);
        add_vec(4'hC, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
        add_vec(4'hE, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
        add_vec(4'hD, 32'h5, 32'h0, 32'hFFFF_FFFF);
        add_vec(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        add_vec(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add_vec(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        add_vec(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add_vec(4'hF, 32'h5, 32'h0, 32'h5);
        add_vec(4'hE, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9);
        add_vec(4'hC, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        add_vec(4'hE, 32'h7, 32'hFFFF_FFFE, 32'h1);
        add_vec(4'h1, 32'h0, 32'h1, 32'hFFFF_FFFF);
        add_vec(4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1);
        add_vec(4'h8, 32'hFFFF_FFFF, 32'h1, 32'h0);
        add_vec(4'h4, 32'h1, 32'h3F, 32'h8000_0000);
        add_vec(4'h9, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
        add_vec(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        add_vec(4'h3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0);
        add_vec(4'hD, 32'd100, 32'd7, 32'd14);
        add_vec(4'hF, 32'd100, 32'd7, 32'd2);
        add_vec(4'hA, 32'h1234_5678, 32'h10, 32'h2345_6780);

        foreach (vq[i]) begin
            send(vq[i].op, vq[i].a, vq[i].b);
            wait_result($sformatf("vec%0d", i), (vq[i].op >= 4'hA) ? 33 : 1, 1'b1, vq[i].r);
        end

        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = 4'(i);
            send(op, $urandom, (i % 5 == 0) ? 32'h0 : $urandom);
            wait_result($sformatf("rnd%0d", i), (op >= 4'hA) ? 33 : 1, 1'b0, 32'h0);
        end

        // Flush ten cycles into a MUL.
        send(4'hA, 32'h1234, 32'h5678);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        repeat (40) @(posedge clk);
        #1;

        // Flush wins over a same-cycle request.
        alu_ctrl = 4'h0; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_valid", 64'(out_valid), 64'(0));
        chk("flush_prio_ready", 64'(in_ready), 64'(1));

        // Asynchronous reset ten cycles into a MUL.
        send(4'hA, 32'hDEAD, 32'hBEEF);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_alu_out", 64'(alu_out), 64'(0));
        chk("arst_flags", 64'({eq, lt, ltu}), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Back-pressure with a second request held on the input.
        out_ready = 1'b0;
        send(4'h0, 32'd3, 32'd4);
        alu_ctrl = 4'h0; op1 = 32'd10; op2 = 32'd20; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_ready", 64'(in_ready), 64'(0));
            chk("hold_data", 64'(alu_out), 64'(7));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("hold_next_valid", 64'(out_valid), 64'(1));
        chk("hold_next_data", 64'(alu_out), 64'(30));
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
